// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO: buffers whole MAC frames, commits on a clean tlast,
// rewinds the write pointer for errored or oversized frames.
module eth_rx_frame_fifo #(
   parameter int DEPTH          = 2048,
   parameter bit DROP_BAD_FRAME = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       status_good_frame,
   output logic       status_bad_frame,
   output logic       status_overflow
);

   localparam int AW     = $clog2(DEPTH);
   localparam int PW     = AW + 1;
   localparam int STAGES = 2;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } beat_t;

   beat_t           mem [DEPTH];
   beat_t           rd_q;
   beat_t           out_q;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   commit_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            drop;
   logic [STAGES:1] vld_pipe;
   logic            full;
   logic            empty;
   logic            ovf_now;
   logic            wr_en;
   logic            rd_en;
   logic            adv;

   assign full    = (wr_ptr - rd_ptr) == PW'(DEPTH);
   assign empty   = (rd_ptr == commit_ptr);
   assign ovf_now = drop | full;
   assign wr_en   = s_axis_tvalid & ~ovf_now;

   // Output register can take a new beat when empty or being drained this cycle;
   // the memory-read stage refills whenever it is empty or moving forward.
   assign adv   = ~vld_pipe[2] | m_axis_tready;
   assign rd_en = ~empty & (~vld_pipe[1] | adv);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
      if (rd_en) rd_q <= mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr            <= '0;
         commit_ptr        <= '0;
         drop              <= 1'b0;
         status_good_frame <= 1'b0;
         status_bad_frame  <= 1'b0;
         status_overflow   <= 1'b0;
      end else begin
         status_good_frame <= 1'b0;
         status_bad_frame  <= 1'b0;
         status_overflow   <= 1'b0;
         if (s_axis_tvalid) begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (s_axis_tlast) begin
               drop <= 1'b0;
               if (ovf_now) begin
                  wr_ptr          <= commit_ptr;
                  status_overflow <= 1'b1;
               end else if (s_axis_tuser && DROP_BAD_FRAME) begin
                  wr_ptr           <= commit_ptr;
                  status_bad_frame <= 1'b1;
               end else begin
                  commit_ptr        <= wr_ptr + PW'(1);
                  status_good_frame <= 1'b1;
               end
            end else if (full && !drop) begin
               // Frame no longer fits: rewind now, swallow the rest up to tlast.
               drop   <= 1'b1;
               wr_ptr <= commit_ptr;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         vld_pipe <= '0;
         out_q    <= '0;
      end else begin
         if (rd_en) begin
            rd_ptr      <= rd_ptr + PW'(1);
            vld_pipe[1] <= 1'b1;
         end else if (adv) begin
            vld_pipe[1] <= 1'b0;
         end
         if (adv) begin
            vld_pipe[2] <= vld_pipe[1];
            out_q       <= rd_q;
         end
      end
   end

   assign m_axis_tvalid = vld_pipe[2];
   assign m_axis_tdata  = out_q.data;
   assign m_axis_tlast  = out_q.last;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Randomized bench for eth_rx_frame_fifo: frame-level reference model with an expected-byte queue.
module tb_eth_rx_frame_fifo;

   localparam int DEPTH = 2048;
   localparam int OC_GOOD = 0;
   localparam int OC_BAD  = 1;
   localparam int OC_OVF  = 2;

   logic       clk;
   logic       rst_n;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tlast;
   logic       s_axis_tuser;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       m_axis_tlast;
   logic       status_good_frame;
   logic       status_bad_frame;
   logic       status_overflow;

   int         n_chk = 0;
   int         n_bad = 0;
   logic [8:0] exp_q[$];
   int         rdy_mode = 0;
   int         rx_beats = 0;
   int         rx_lasts = 0;
   bit         prev_stall;
   logic [8:0] prev_beat;

   eth_rx_frame_fifo #(.DEPTH(DEPTH), .DROP_BAD_FRAME(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .status_good_frame(status_good_frame), .status_bad_frame(status_bad_frame),
      .status_overflow(status_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Frame fits if its length is within the space not yet handed downstream.
   function automatic int predict(input int len, input bit tu);
      int free_b;
      free_b = DEPTH - exp_q.size();
      if (len > free_b) return OC_OVF;
      if (tu) return OC_BAD;
      return OC_GOOD;
   endfunction

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'b0;
            default: m_axis_tready = 1'($urandom_range(1));
         endcase
      end
   end

   initial begin
      prev_stall = 1'b0;
      prev_beat  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_vld", 32'(m_axis_tvalid), 32'd1);
               chk("stall_data", 32'({m_axis_tlast, m_axis_tdata}), 32'(prev_beat));
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_q.size() == 0) chk("spurious_beat", 32'(m_axis_tvalid), 32'd0);
               else chk("beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_q.pop_front()));
               rx_beats++;
               if (m_axis_tlast) rx_lasts++;
            end
         end
      end
   end

   // Entered and left at posedge+1.
   task automatic send_frame(input int len, input bit tu, input int gap_pct, input bit lat);
      logic [8:0] fr[$];
      logic [7:0] b;
      logic [2:0] st_exp;
      int         oc;
      oc = predict(len, tu);
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom_range(255));
         fr.push_back({(i == len - 1), b});
      end
      for (int i = 0; i < len; i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = fr[i][7:0];
         s_axis_tlast  = fr[i][8];
         s_axis_tuser  = fr[i][8] ? tu : 1'($urandom_range(1));
         @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      @(negedge clk);
      st_exp = (oc == OC_GOOD) ? 3'b100 : (oc == OC_BAD) ? 3'b010 : 3'b001;
      chk("status", 32'({status_good_frame, status_bad_frame, status_overflow}), 32'(st_exp));
      if (oc == OC_GOOD) foreach (fr[i]) exp_q.push_back(fr[i]);
      @(negedge clk);
      chk("pulse_once", 32'({status_good_frame, status_bad_frame, status_overflow}), 32'd0);
      if (lat) begin
         chk("lat_edge1", 32'(m_axis_tvalid), 32'd0);
         @(negedge clk);
         chk("lat_edge2", 32'(m_axis_tvalid), 32'd1);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int b0, l0, len;
      bit tu;
      rst_n = 1'b0;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata,
                            status_good_frame, status_bad_frame, status_overflow}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 60-byte good frame with latency check
      rdy_mode = 0;
      send_frame(60, 1'b0, 0, 1'b1);
      wait_drain(500);

      // errored frame dropped, then a clean one
      send_frame(64, 1'b1, 0, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      chk("bad_no_vld", 32'(m_axis_tvalid), 32'd0);
      send_frame(64, 1'b0, 0, 1'b0);
      wait_drain(500);

      // stalled output fills buffer: third frame overflows
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      b0 = rx_beats;
      l0 = rx_lasts;
      send_frame(1000, 1'b0, 0, 1'b0);
      send_frame(1000, 1'b0, 0, 1'b0);
      send_frame(100, 1'b0, 0, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      rdy_mode = 0;
      wait_drain(6000);
      chk("ovf_bytes", 32'(rx_beats - b0), 32'd2000);
      chk("ovf_lasts", 32'(rx_lasts - l0), 32'd2);

      // oversize frame never forwarded
      send_frame(3000, 1'b0, 0, 1'b0);
      send_frame(64, 1'b0, 0, 1'b0);
      wait_drain(500);

      // random backpressure, 64-byte frames
      rdy_mode = 2;
      for (int f = 0; f < 20; f++) begin
         send_frame(64, 1'b0, 20, 1'b0);
         repeat (100) @(posedge clk);
         #1;
      end
      wait_drain(2000);

      // mixed lengths and errors
      for (int f = 0; f < 15; f++) begin
         len = int'($urandom_range(300, 1));
         tu  = ($urandom_range(3) == 0);
         send_frame(len, tu, 10, 1'b0);
         repeat (2 * len + 20) @(posedge clk);
         #1;
      end
      wait_drain(4000);

      // reset in the middle of output
      rdy_mode = 0;
      send_frame(200, 1'b0, 0, 1'b0);
      repeat (100) @(posedge clk);
      #1;
      chk("mid_vld", 32'(m_axis_tvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata,
                            status_good_frame, status_bad_frame, status_overflow}), 32'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(64, 1'b0, 0, 1'b1);
      wait_drain(500);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/eth_rx_frame_fifo.md
ETH_RX_FRAME_FIFO -- requirements
Module: eth_rx_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, buffer capacity in bytes; power of two, 64..65536.
REQ-002 SHALL have parameter DROP_BAD_FRAME, default 1; 1 = discard frames ending with s_axis_tuser=1, 0 = forward them.
REQ-003 SHALL have port clk  input  1  single clock for all logic; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_axis_tdata  input  8  receive byte from MAC.
REQ-006 SHALL have port s_axis_tvalid  input  1  byte valid; no backpressure exists, every valid beat is consumed.
REQ-007 SHALL have port s_axis_tlast  input  1  last byte of frame.
REQ-008 SHALL have port s_axis_tuser  input  1  frame error, meaningful only with tlast.
REQ-009 SHALL have port m_axis_tdata  output  8  buffered byte.
REQ-010 SHALL have port m_axis_tvalid  output  1  output byte valid.
REQ-011 SHALL have port m_axis_tready  input  1  downstream accept.
REQ-012 SHALL have port m_axis_tlast  output  1  last byte of forwarded frame.
REQ-013 SHALL have port status_good_frame  output  1  one-cycle pulse, frame committed.
REQ-014 SHALL have port status_bad_frame  output  1  one-cycle pulse, frame dropped for tuser.
REQ-015 SHALL have port status_overflow  output  1  one-cycle pulse, frame dropped for lack of space.

Function
REQ-016 SHALL be store-and-forward: no byte of a frame appears on m_axis before that frame's tlast beat is accepted and committed.
REQ-017 SHALL store {tlast, tdata} per entry in a DEPTH-entry memory with synchronous read.
REQ-018 SHALL keep wr_ptr, commit_ptr, rd_ptr each log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = (wr_ptr - rd_ptr == DEPTH), empty = (rd_ptr == commit_ptr).
REQ-019 SHALL on a valid beat with drop flag clear and not full: write entry at wr_ptr, wr_ptr+1.
REQ-020 SHALL on a valid beat while full: set drop flag, wr_ptr <= commit_ptr, byte discarded.
REQ-021 SHALL discard all beats while drop flag set; drop flag clears on the tlast beat.
REQ-022 SHALL on tlast beat: if drop flag set or overflow this beat -> wr_ptr <= commit_ptr, pulse status_overflow; else if tuser=1 and DROP_BAD_FRAME=1 -> wr_ptr <= commit_ptr, pulse status_bad_frame; else commit_ptr <= wr_ptr+1, pulse status_good_frame.
REQ-023 SHALL register status pulses: asserted exactly the cycle after the tlast edge, exactly one pulse per frame.
REQ-024 SHALL drop any frame longer than DEPTH bytes (overflow path), never partially forward it.
REQ-025 SHALL have a two-stage read pipeline (memory read, output register) with full throughput: one byte per cycle while m_axis_tready=1 and data committed.
REQ-026 SHALL assert m_axis_tvalid for the first byte of a frame on the second rising edge after the edge accepting its tlast, when the output path was idle.
REQ-027 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid=1 and m_axis_tready=0; tvalid never deasserts without a handshake.
REQ-028 SHALL free a memory entry (rd_ptr+1) only when it is loaded into the read pipeline; full computed from current rd_ptr, so simultaneous read and write in one cycle both take effect.
REQ-029 SHALL forward back-to-back committed frames with no idle cycle between a tlast byte and the next frame's first byte.
REQ-030 SHALL treat a frame tail arriving after reset release as a complete frame (framing is upstream's responsibility).

Reset
REQ-031 SHALL on rst_n=0 asynchronously clear wr_ptr, commit_ptr, rd_ptr, drop flag, read pipeline; m_axis_tvalid, m_axis_tlast, m_axis_tdata, all status outputs = 0.
REQ-032 SHALL discard any partial or committed-but-unread frame on reset; memory contents need not be cleared.

Verification
REQ-033 60-byte frame, tuser=0, tready=1 -> status_good_frame pulse 1 cycle after tlast; 60 bytes on m_axis, first valid 2 edges after tlast, tlast on byte 60 only.
REQ-034 64-byte frame tlast with tuser=1, DROP_BAD_FRAME=1 -> status_bad_frame pulse, m_axis_tvalid stays 0; following good 64-byte frame forwarded intact.
REQ-035 DEPTH=2048, tready=0, frames of 1000,1000,100 bytes -> first two good, third status_overflow; release tready -> exactly 2000 bytes, 2 tlasts.
REQ-036 3000-byte frame, DEPTH=2048, tready=1 -> status_overflow, nothing forwarded; next 64-byte frame forwarded.
REQ-037 tready toggled randomly while receiving continuous 64-byte frames -> byte order and tlast positions preserved, no loss, data stable under stall.
REQ-038 rst_n low mid-output (frame half read) -> all outputs 0 immediately; after release, next 64-byte frame forwarded correctly.
